johnson_phase_monitor: RTL

Downstream consumer of the johnson counter's `Count_out` bus. It registers the Johnson code and decodes it into a binary phase index and a one-hot phase vector. It also checks every sample for a legal code and a legal step, and tracks lock status. It reports errors as single-cycle pulses and as a saturating count.

---
 rtl/johnson_phase_monitor_if.sv | 26 ++
 rtl/johnson_phase_monitor.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/johnson_phase_monitor_if.sv
// Bundles the Johnson code input, the error-clear input and the decoded status outputs.
interface johnson_phase_monitor_if #(
    parameter int WIDTH = 4
);
    localparam int PW = $clog2(2 * WIDTH);

    logic [WIDTH-1:0]   Count_in;
    logic               Err_clr;
    logic [PW-1:0]      Phase;
    logic [2*WIDTH-1:0] Phase_onehot;
    logic               Valid;
    logic               Locked;
    logic               Error;
    logic               Wrap;
    logic [7:0]         Err_count;

    modport master (
        output Count_in, Err_clr,
        input  Phase, Phase_onehot, Valid, Locked, Error, Wrap, Err_count
    );

    modport slave (
        input  Count_in, Err_clr,
        output Phase, Phase_onehot, Valid, Locked, Error, Wrap, Err_count
    );
endinterface

// File: rtl/johnson_phase_monitor.sv
// Registers a Johnson code, decodes phase/one-hot, checks legality and step order, and tracks lock.
// Latency: 2 edges from Count_in to every status output; Err_count moves together with Error.
// Backpressure: none, a new code is accepted on every edge.
module johnson_phase_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 8
) (
    input  logic                    Clock,
    input  logic                    Reset_n,
    johnson_phase_monitor_if.slave  mon
);
    localparam int PW = $clog2(2 * WIDTH);

    localparam logic [1:0] ST_ACQUIRE = 2'd0;
    localparam logic [1:0] ST_TRACK   = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam logic [PW-1:0]      LAST_PH = PW'(2 * WIDTH - 1);
    localparam logic [7:0]         LOCK_C  = 8'(LOCK_CNT);
    localparam logic [2*WIDTH-1:0] ONE     = {{(2*WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]   sample_q, sample_d;
    logic [PW-1:0]      phase_q, phase_d;
    logic [2*WIDTH-1:0] onehot_q, onehot_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               error_q, error_d;
    logic               wrap_q, wrap_d;
    logic [7:0]         err_cnt_q, err_cnt_d;
    logic [7:0]         run_q, run_d;
    logic [1:0]         state_q, state_d;

    logic [PW-1:0]      ones, diffs, p, phase_inc;
    logic [7:0]         run_inc;
    logic               legal, good_step, stall;

    // A Johnson code is a single run of ones and a single run of zeros,
    // so at most one adjacent pair of bits may differ.
    always_comb begin
        ones  = '0;
        diffs = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones = ones + PW'(sample_q[i]);
        end
        for (int i = 0; i < WIDTH - 1; i++) begin
            diffs = diffs + PW'(sample_q[i] ^ sample_q[i+1]);
        end
        legal     = (diffs <= PW'(1));
        p         = sample_q[WIDTH-1] ? (PW'(WIDTH) + (PW'(WIDTH) - ones)) : ones;
        phase_inc = (phase_q == LAST_PH) ? '0 : (phase_q + PW'(1));
        good_step = (p == phase_inc);
        stall     = (p == phase_q);
    end

    always_comb begin
        sample_d = mon.Count_in;
        state_d  = state_q;
        run_d    = run_q;
        error_d  = 1'b0;
        wrap_d   = 1'b0;
        run_inc  = (run_q >= LOCK_C) ? LOCK_C : (run_q + 8'd1);

        case (state_q)
            ST_ACQUIRE: begin
                if (legal) begin
                    state_d = ST_TRACK;
                    run_d   = '0;
                end else begin
                    error_d = 1'b1;
                end
            end
            ST_TRACK: begin
                if (!legal) begin
                    state_d = ST_ACQUIRE;
                    error_d = 1'b1;
                    run_d   = '0;
                end else if (good_step) begin
                    run_d  = run_inc;
                    wrap_d = (phase_q == LAST_PH);
                    if (run_inc == LOCK_C) begin
                        state_d = ST_LOCKED;
                    end
                end else if (!stall) begin
                    error_d = 1'b1;
                    run_d   = '0;
                end
            end
            ST_LOCKED: begin
                if (!legal) begin
                    state_d = ST_ACQUIRE;
                    error_d = 1'b1;
                    run_d   = '0;
                end else if (good_step) begin
                    wrap_d = (phase_q == LAST_PH);
                end else if (!stall) begin
                    state_d = ST_TRACK;
                    error_d = 1'b1;
                    run_d   = '0;
                end
            end
            default: begin
                state_d = ST_ACQUIRE;
                run_d   = '0;
            end
        endcase

        // Illegal codes leave the last good phase visible but drop Valid.
        phase_d  = legal ? p : phase_q;
        valid_d  = legal;
        onehot_d = legal ? (ONE << p) : '0;
        locked_d = (state_d == ST_LOCKED);

        if (mon.Err_clr) begin
            err_cnt_d = {7'd0, error_d};
        end else if (error_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            sample_q  <= '0;
            phase_q   <= '0;
            onehot_q  <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            error_q   <= 1'b0;
            wrap_q    <= 1'b0;
            err_cnt_q <= '0;
            run_q     <= '0;
            state_q   <= ST_ACQUIRE;
        end else begin
            sample_q  <= sample_d;
            phase_q   <= phase_d;
            onehot_q  <= onehot_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            error_q   <= error_d;
            wrap_q    <= wrap_d;
            err_cnt_q <= err_cnt_d;
            run_q     <= run_d;
            state_q   <= state_d;
        end
    end

    assign mon.Phase        = phase_q;
    assign mon.Phase_onehot = onehot_q;
    assign mon.Valid        = valid_q;
    assign mon.Locked       = locked_q;
    assign mon.Error        = error_q;
    assign mon.Wrap         = wrap_q;
    assign mon.Err_count    = err_cnt_q;
endmodule
